// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for 8 requesters with index and one-hot grant outputs.
// Optional forced release after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module rr_decode_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic       gnt_valid,
    output logic [2:0] gnt_idx,
    output logic [7:0] gnt_onehot,
    output logic       timeout
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state, state_n;
    logic [2:0] ptr, ptr_n;
    logic       valid_n;
    logic [2:0] idx_n;
    logic [7:0] oh_n;
    logic [2:0] win, cand;
    logic       found;
    logic       release_n;

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
        $error("MAX_HOLD out of range");
    end

    // First set request scanning upward from ptr, wrapping 7 -> 0.
    always_comb begin
        win   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            cand = ptr + 3'(k);
            if (!found && req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_cnt, cnt_n;
    logic       to_n, forced;
`endif

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        valid_n   = gnt_valid;
        idx_n     = gnt_idx;
        oh_n      = gnt_onehot;
        release_n = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_n  = hold_cnt;
        to_n   = 1'b0;
        forced = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_n = BUSY;
                    valid_n = 1'b1;
                    idx_n   = win;
                    oh_n    = 8'b1 << win;
`ifdef ARB_TIMEOUT_EN
                    cnt_n = '0;
`endif
                end
            end
            BUSY: begin
                release_n = done || !req[gnt_idx];
`ifdef ARB_TIMEOUT_EN
                forced = !release_n && (hold_cnt == 8'(MAX_HOLD - 1));
                to_n   = forced;
                if (!release_n && !forced)
                    cnt_n = hold_cnt + 8'd1;
                release_n = release_n || forced;
`endif
                if (release_n) begin
                    state_n = IDLE;
                    ptr_n   = gnt_idx + 3'd1;
                    valid_n = 1'b0;
                    idx_n   = '0;
                    oh_n    = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            gnt_valid  <= 1'b0;
            gnt_idx    <= '0;
            gnt_onehot <= '0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            gnt_valid  <= valid_n;
            gnt_idx    <= idx_n;
            gnt_onehot <= oh_n;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            hold_cnt <= cnt_n;
            timeout  <= to_n;
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Bench for rr_decode_arbiter: directed scenarios plus random traffic
// checked against an owner/pointer reference model.
module tb_rr_decode_arbiter;

    localparam int MH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = '0;
    logic       done = 1'b0;
    logic       gnt_valid;
    logic [2:0] gnt_idx;
    logic [7:0] gnt_onehot;
    logic       timeout;

    int checks = 0;
    int failures = 0;

    int owner = -1;
    int ptr = 0;
    int held = 0;
    logic exp_to = 1'b0;

    rr_decode_arbiter #(.MAX_HOLD(MH)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .done(done),
        .gnt_valid(gnt_valid),
        .gnt_idx(gnt_idx),
        .gnt_onehot(gnt_onehot),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input logic r, input logic [7:0] q,
                              input logic d);
        logic rel;
        rel = 1'b0;
        exp_to = 1'b0;
        if (r) begin
            owner = -1;
            ptr = 0;
            held = 0;
        end else if (owner < 0) begin
            for (int k = 0; k < 8; k++)
                if (owner < 0 && q[(ptr + k) % 8])
                    owner = (ptr + k) % 8;
            held = 0;
        end else begin
            if (d || !q[owner]) rel = 1'b1;
`ifdef ARB_TIMEOUT_EN
            else if (held == MH - 1) begin
                rel = 1'b1;
                exp_to = 1'b1;
            end else held++;
`endif
            if (rel) begin
                ptr = (owner + 1) % 8;
                owner = -1;
            end
        end
    endtask

    task automatic step(input logic r, input logic [7:0] q,
                        input logic d, input string tag);
        rst = r;
        req = q;
        done = d;
        @(posedge clk);
        model_step(r, q, d);
        #1;
        chk({tag, ".valid"}, 32'(gnt_valid), 32'(owner >= 0));
        chk({tag, ".idx"}, 32'(gnt_idx),
            (owner >= 0) ? 32'(owner) : 32'd0);
        chk({tag, ".onehot"}, 32'(gnt_onehot),
            (owner >= 0) ? (32'd1 << owner) : 32'd0);
        chk({tag, ".timeout"}, 32'(timeout), 32'(exp_to));
    endtask

    initial begin
        logic [7:0] rq;
        // reset held with all requests pending
        step(1, 8'hFF, 0, "rst");
        step(1, 8'hFF, 0, "rst");
        step(0, 8'hFF, 0, "first");
        chk("first_idx0", 32'(gnt_idx), 32'd0);
        chk("first_oh01", 32'(gnt_onehot), 32'h01);

        // full rotation with done on every grant
        for (int i = 0; i < 18; i++)
            step(0, 8'hFF, gnt_valid, "rot");

        // wrap scan from ptr=6
        step(1, 8'h00, 0, "rst");
        step(0, 8'h20, 0, "g5");
        step(0, 8'h20, 1, "rel5");
        step(0, 8'h05, 0, "wrap");
        chk("wrap_idx0", 32'(gnt_idx), 32'd0);
        step(0, 8'h05, 1, "rel0");
        step(0, 8'h05, 0, "next");
        chk("next_idx2", 32'(gnt_idx), 32'd2);

        // owner withdraws without done
        step(1, 8'h00, 0, "rst");
        step(0, 8'h08, 0, "g3");
        step(0, 8'h20, 0, "drop3");
        chk("drop_gap", 32'(gnt_valid), 32'd0);
        step(0, 8'h20, 0, "g5b");
        chk("g5_oh", 32'(gnt_onehot), 32'h20);

        // done ignored in idle; reset mid-busy
        step(0, 8'h00, 1, "idle_done");
        step(0, 8'h00, 1, "idle_done");
        step(0, 8'hF0, 0, "busy");
        step(1, 8'hF0, 0, "mid_rst");
        step(0, 8'hFF, 0, "after_rst");
        chk("after_rst_idx0", 32'(gnt_idx), 32'd0);

        // single held requester: timeout or indefinite hold
        step(1, 8'h00, 0, "rst");
        for (int i = 0; i < 14; i++)
            step(0, 8'h01, 0, "hold");

        // random traffic
        rq = 8'($urandom);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(3) == 0) rq = 8'($urandom);
            step($urandom_range(49) == 0, rq,
                 $urandom_range(3) == 0, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
